// File: rtl/imm_gen_pipe.sv
// Immediate generator with a two-entry output buffer (main + skid).
// Decodes the immediate format from the opcode/funct3, computes the target
// pc + imm, and hands results downstream over a valid/ready handshake.
// in_ready comes straight from a flop, so there is no combinational path
// from out_ready back to the upstream stage.
module imm_gen_pipe #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      imm_type,
    output logic [XLEN-1:0] tgt,
    output logic [XLEN-1:0] pc_out
);

    localparam logic [2:0] T_NONE = 3'd0;
    localparam logic [2:0] T_I    = 3'd1;
    localparam logic [2:0] T_S    = 3'd2;
    localparam logic [2:0] T_B    = 3'd3;
    localparam logic [2:0] T_U    = 3'd4;
    localparam logic [2:0] T_J    = 3'd5;
    localparam logic [2:0] T_Z    = 3'd6;
    localparam logic [2:0] T_SH   = 3'd7;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      typ;
        logic [XLEN-1:0] tgt;
        logic [XLEN-1:0] pc;
    } entry_t;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_type;
    entry_t          new_e;

    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   main_valid_q, main_valid_d;
    logic   skid_valid_q, skid_valid_d;

    logic fire_in;
    logic fire_out;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];

    // Format decode: pick the immediate layout and sign/zero-extend to XLEN
    always_comb begin
        dec_imm  = '0;
        dec_type = T_NONE;
        case (opcode)
            OP_LOAD, OP_JALR: begin
                dec_type = T_I;
                dec_imm  = XLEN'($signed(inst[31:20]));
            end
            OP_IMM: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    dec_type = T_SH;
                    dec_imm  = XLEN'(inst[20 +: SHAMT_W]);
                end else begin
                    dec_type = T_I;
                    dec_imm  = XLEN'($signed(inst[31:20]));
                end
            end
            OP_IMM32: begin
                // Word-sized shifts only exist on the 64-bit datapath
                if (XLEN == 64) begin
                    if (funct3 == 3'b001 || funct3 == 3'b101) begin
                        dec_type = T_SH;
                        dec_imm  = XLEN'(inst[24:20]);
                    end else begin
                        dec_type = T_I;
                        dec_imm  = XLEN'($signed(inst[31:20]));
                    end
                end
            end
            OP_STORE: begin
                dec_type = T_S;
                dec_imm  = XLEN'($signed({inst[31:25], inst[11:7]}));
            end
            OP_BRANCH: begin
                dec_type = T_B;
                dec_imm  = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
            end
            OP_LUI, OP_AUIPC: begin
                dec_type = T_U;
                dec_imm  = XLEN'($signed({inst[31:12], 12'h000}));
            end
            OP_JAL: begin
                dec_type = T_J;
                dec_imm  = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
            end
            OP_SYSTEM: begin
                if (funct3[2]) begin
                    dec_type = T_Z;
                    dec_imm  = XLEN'(inst[19:15]);
                end else if (funct3 != 3'b000) begin
                    dec_type = T_I;
                    dec_imm  = XLEN'($signed(inst[31:20]));
                end
            end
            default: begin
                dec_imm  = '0;
                dec_type = T_NONE;
            end
        endcase
    end

    // Pack the decoded result into a buffer entry; target wraps modulo 2^XLEN
    always_comb begin
        new_e.imm = dec_imm;
        new_e.typ = dec_type;
        new_e.tgt = pc + dec_imm;
        new_e.pc  = pc;
    end

    assign in_ready  = ~skid_valid_q;
    assign out_valid = main_valid_q;
    assign fire_in   = in_valid & in_ready;
    assign fire_out  = main_valid_q & out_ready;

    // Buffer control: flush wins, then drain skid, then accept into main or skid
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            // in_ready is low here, so nothing new can arrive this cycle
            if (fire_out) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end
        end else if (fire_in) begin
            if (!main_valid_q || fire_out) begin
                main_d       = new_e;
                main_valid_d = 1'b1;
            end else begin
                skid_d       = new_e;
                skid_valid_d = 1'b1;
            end
        end else if (fire_out) begin
            main_valid_d = 1'b0;
        end
    end

    // State registers; reset clears valids and data immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign imm      = main_q.imm;
    assign imm_type = main_q.typ;
    assign tgt      = main_q.tgt;
    assign pc_out   = main_q.pc;

endmodule
